// File: rtl/if_else_pkg.sv
// Shared definitions for the if_else conditional-copy sequencer and its ram2 companion.
// Holds the state encoding, the fixed addresses and the key value the program tests against.
package if_else_pkg;

  localparam int AddrWidth = 5;
  localparam int DataWidth = 32;
  localparam int Depth     = 32;

  typedef enum logic [2:0] {
    RD4,
    CMP,
    WR,
    WAIT,
    DONE
  } state_e;

  localparam logic [AddrWidth-1:0] DstAddr  = 5'd0;
  localparam logic [AddrWidth-1:0] SrcAddr  = 5'd3;
  localparam logic [AddrWidth-1:0] KeyAddr  = 5'd4;
  localparam logic [DataWidth-1:0] KeyValue = 32'd3;

  // Full-width unsigned compare so that values such as 32'h103 do not alias to the key.
  function automatic logic isKeyMatch(input logic [DataWidth-1:0] word);
    return word == KeyValue;
  endfunction

endpackage

// File: rtl/ram2.sv
// 32x32 memory with two registered read ports, one write port and a debug port.
// Contents are never cleared, so they survive reset and unwritten words read X.
module ram2
  import if_else_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AddrWidth-1:0] raddr0,
  output logic [DataWidth-1:0] rdata0,
  input  logic [AddrWidth-1:0] raddr1,
  output logic [DataWidth-1:0] rdata1,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic                 wen,
  input  logic [AddrWidth-1:0] debug_addr,
  output logic [DataWidth-1:0] debug_data,
  input  logic [AddrWidth-1:0] debug_write_addr,
  input  logic [DataWidth-1:0] debug_write_data,
  input  logic                 debug_write_en
);

  logic [DataWidth-1:0] mem [Depth];
  logic [DataWidth-1:0] rdata0_q;
  logic [DataWidth-1:0] rdata1_q;

  // Only the debug port may load memory while reset is held; it is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (wen && rst) begin
      mem[waddr] <= wdata;
    end
    if (debug_write_en) begin
      mem[debug_write_addr] <= debug_write_data;
    end
  end

  always_ff @(posedge clk) begin
    rdata0_q <= mem[raddr0];
    rdata1_q <= mem[raddr1];
  end

  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign debug_data = mem[debug_addr];

endmodule

// File: rtl/if_else.sv
// One-shot sequencer: after each reset release, copies mem[3] into mem[0] when mem[4] equals 3.
// Outputs decode straight from state so an asserted reset cancels a pending write at once.
module if_else
  import if_else_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  output logic                 valid,
  output logic [AddrWidth-1:0] raddr_0,
  input  logic [DataWidth-1:0] rdata_0,
  output logic [AddrWidth-1:0] waddr_0,
  output logic [DataWidth-1:0] wdata_0,
  output logic                 wen_0
);

  state_e state_q, state_d;
  logic   cond_q, cond_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RD4;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
    end
  end

  // Read data lags the address by a cycle: CMP sees mem[4], WR sees mem[3].
  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    raddr_0 = '0;
    waddr_0 = '0;
    wdata_0 = '0;
    wen_0   = 1'b0;
    valid   = 1'b0;
    case (state_q)
      RD4: begin
        raddr_0 = KeyAddr;
        state_d = CMP;
      end
      CMP: begin
        cond_d  = isKeyMatch(rdata_0);
        raddr_0 = SrcAddr;
        state_d = WR;
      end
      WR: begin
        waddr_0 = DstAddr;
        wdata_0 = rdata_0;
        wen_0   = cond_q;
        state_d = WAIT;
      end
      WAIT: begin
        state_d = DONE;
      end
      DONE: begin
        valid = 1'b1;
      end
      default: begin
        state_d = RD4;
      end
    endcase
  end

endmodule

// File: tb/tb_if_else.sv
// Bench for if_else wired to ram2 as an integrator would; memory is loaded and inspected via the debug port.
// A plain array holds the expected memory and the program outcome is derived from it directly.
module tb_if_else;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [4:0]  raddr_0;
  logic [31:0] rdata_0;
  logic [4:0]  waddr_0;
  logic [31:0] wdata_0;
  logic        wen_0;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  debugAddr;
  logic [31:0] debugData;
  logic [4:0]  debugWriteAddr;
  logic [31:0] debugWriteData;
  logic        debugWriteEn;

  int          vectorCount = 0;
  int          missCount   = 0;
  logic [31:0] modelMem [32];
  logic [31:0] allX;

  if_else dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .raddr_0 (raddr_0),
    .rdata_0 (rdata_0),
    .waddr_0 (waddr_0),
    .wdata_0 (wdata_0),
    .wen_0   (wen_0)
  );

  ram2 ramInst (
    .clk              (clk),
    .rst              (rst),
    .raddr0           (raddr_0),
    .rdata0           (rdata_0),
    .raddr1           (raddr1),
    .rdata1           (rdata1),
    .waddr            (waddr_0),
    .wdata            (wdata_0),
    .wen              (wen_0),
    .debug_addr       (debugAddr),
    .debug_data       (debugData),
    .debug_write_addr (debugWriteAddr),
    .debug_write_data (debugWriteData),
    .debug_write_en   (debugWriteEn)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic debugWrite(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    debugWriteAddr = addr;
    debugWriteData = data;
    debugWriteEn   = 1'b1;
    @(negedge clk);
    debugWriteEn   = 1'b0;
    modelMem[addr] = data;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, {31'b0, valid}, 32'd0);
    checkOutput({tag, "_raddr"}, {27'b0, raddr_0}, 32'd4);
    checkOutput({tag, "_wen"}, {31'b0, wen_0}, 32'd0);
    checkOutput({tag, "_waddr"}, {27'b0, waddr_0}, 32'd0);
    checkOutput({tag, "_wdata"}, wdata_0, 32'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] key, input logic [31:0] src);
    @(negedge clk);
    rst = 1'b0;
    debugWrite(5'd4, key);
    debugWrite(5'd3, src);
    #1 checkResetOutputs(tag);
  endtask

  // Releases reset and follows the program edge by edge against the expected timeline.
  task automatic runProgram(input string tag);
    logic        takes;
    logic [31:0] finalDst;
    takes    = (modelMem[4] === 32'd3);
    finalDst = takes ? modelMem[3] : modelMem[0];
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput({tag, "_raddr_e0"}, {27'b0, raddr_0}, 32'd4);
    for (int edgeNo = 1; edgeNo <= 7; edgeNo++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_valid"}, {31'b0, valid}, {31'b0, edgeNo >= 4});
      checkOutput({tag, "_wen"}, {31'b0, wen_0}, {31'b0, (edgeNo == 2) && takes});
      if (edgeNo == 1) checkOutput({tag, "_raddr_e1"}, {27'b0, raddr_0}, 32'd3);
      if (edgeNo == 2) begin
        checkOutput({tag, "_waddr"}, {27'b0, waddr_0}, 32'd0);
        checkOutput({tag, "_wdata"}, wdata_0, modelMem[3]);
      end
    end
    modelMem[0] = finalDst;
    debugAddr = 5'd0;
    #1 checkOutput({tag, "_mem0"}, debugData, modelMem[0]);
  endtask

  initial begin
    logic [31:0] key;
    logic [31:0] src;
    allX           = 'x;
    rst            = 1'b0;
    raddr1         = 5'd0;
    debugAddr      = 5'd0;
    debugWriteAddr = 5'd0;
    debugWriteData = 32'd0;
    debugWriteEn   = 1'b0;
    for (int i = 0; i < 32; i++) modelMem[i] = 'x;

    applyStimulus("load23", 32'd3, 32'd23);
    debugAddr = 5'd0;
    #1 checkOutput("unwritten_mem0", debugData, allX);
    runProgram("copy23");

    applyStimulus("load18", 32'd2, 32'd18);
    runProgram("nocopy18");

    applyStimulus("load103", 32'h0000_0103, 32'h55);
    runProgram("key103");

    applyStimulus("loadAllOnes", 32'd3, 32'hFFFF_FFFF);
    runProgram("allOnes");

    // Reset pulled while WR is driving a real write: nothing may land in mem[0].
    applyStimulus("abortLoad", 32'd3, 32'h1234_5678);
    debugWrite(5'd0, 32'hCAFE_0001);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 checkOutput("abort_wenBefore", {31'b0, wen_0}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_wenAfter", {31'b0, wen_0}, 32'd0);
    checkOutput("abort_valid", {31'b0, valid}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    debugAddr = 5'd0;
    #1 checkOutput("abort_mem0", debugData, modelMem[0]);
    runProgram("abortRerun");

    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 3))
        0:       key = 32'd3;
        1:       key = 32'h0000_0103;
        2:       key = $urandom;
        default: key = 32'h8000_0003;
      endcase
      src = $urandom;
      applyStimulus("randLoad", key, src);
      if ($urandom_range(0, 1) == 1) debugWrite(5'd0, $urandom);
      runProgram($sformatf("rand%0d", n));
    end

    raddr1 = 5'd3;
    @(posedge clk);
    #1 checkOutput("port1_read", rdata1, modelMem[3]);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/if_else.md
IF_ELSE -- requirements
Module: if_else

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock.
REQ-003 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-004 Port valid, output, 1 bit: program complete, sticky until reset.
REQ-005 Port raddr_0, output, 5 bits: read address to RAM port 0.
REQ-006 Port rdata_0, input, 32 bits: RAM read data, registered one cycle after raddr_0.
REQ-007 Port waddr_0, output, 5 bits: RAM write address.
REQ-008 Port wdata_0, output, 32 bits: RAM write data.
REQ-009 Port wen_0, output, 1 bit: RAM write enable; the write occurs at the rising clock edge while wen_0 is high.

Function
REQ-010 The block SHALL execute once per reset release: if mem[4] == 3 then mem[0] = mem[3]; otherwise memory is left unchanged.
REQ-011 The FSM SHALL have the states RD4, CMP, WR, WAIT and DONE, and SHALL advance exactly one state per clock edge in the order RD4->CMP->WR->WAIT->DONE; DONE is absorbing.
REQ-012 RD4 SHALL drive raddr_0=4 and wen_0=0.
REQ-013 CMP SHALL register cond = (rdata_0 == 32'd3), a full 32-bit unsigned compare, and drive raddr_0=3 and wen_0=0.
REQ-014 WR SHALL drive waddr_0=0, wdata_0=rdata_0 and wen_0=cond.
REQ-015 WAIT and DONE SHALL drive wen_0=0; in these states raddr_0 and waddr_0 SHALL be 0 and wdata_0 SHALL be 0.
REQ-016 valid SHALL be 1 only in DONE, first asserted after the 4th rising edge following reset deassertion, with identical latency on both branches.
REQ-017 valid SHALL be 0 after the 2nd and 3rd edges following reset release.
REQ-018 rdata_0 SHALL be consumed only in CMP and WR; values of rdata_0 in other states are don't-care.
REQ-019 Reset asserted mid-program SHALL abort the program immediately, with no write issued; the next release restarts from RD4.

Reset
REQ-020 While rst=0: state=RD4, cond=0, valid=0, wen_0=0, raddr_0=4, waddr_0=0, wdata_0=0.
REQ-021 Reset SHALL NOT affect memory contents; they persist across reset.

Structure
REQ-022 The FSM state encoding and the constants addresses 0/3/4 and compare value 3 SHALL reside in a shared package if_else_pkg.
REQ-023 The companion memory ram2 SHALL be delivered as a separate module and instantiated beside if_else by the integrator, not inside it.
REQ-024 ram2 SHALL be 32 entries x 32 bits with 5-bit addresses.
REQ-025 ram2 ports: clk, rst, raddr0, rdata0, raddr1, rdata1, waddr, wdata, wen, debug_addr, debug_data, debug_write_addr, debug_write_data, debug_write_en.
REQ-026 ram2 read ports rdata0 and rdata1 SHALL be registered: value = mem[addr] sampled at the clock edge.
REQ-027 ram2 debug_data SHALL be combinational: mem[debug_addr].
REQ-028 ram2 writes SHALL be synchronous; debug writes SHALL function during reset; when both write ports target the same address in one cycle, the debug write SHALL win.
REQ-029 ram2 memory SHALL NOT be initialised, so unwritten words read X in simulation.

Verification
REQ-030 Load mem[4]=3 and mem[3]=23 via the debug port under reset; while still in reset, debug_addr=0 -> debug_data=X and valid=0.
REQ-031 After release of the load in REQ-030 -> valid=0 after edges 2 and 3, valid=1 after edge 4, and mem[0]=23 after 7 edges.
REQ-032 Then reload mem[4]=2 and mem[3]=18 under reset and release -> mem[0] stays 23, valid=0 during reset, valid=1 after edge 4.
REQ-033 Boundary value: mem[4]=32'h00000103 -> no write.
REQ-034 Boundary value: mem[4]=3 with mem[3]=32'hFFFFFFFF -> mem[0]=32'hFFFFFFFF.
REQ-035 Assert rst in WR with cond=1 -> no write to mem[0], valid=0; after release, the full sequence reruns.
